// File: rtl/adder_sum_accumulator_if.sv
// Stream bundle for the adder result accumulator: sample input stream plus block-total output stream.
interface adder_sum_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT {carry, sum} adder results per block and holds the total until accepted.
// Define ADDER_SUM_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ACCUM | accepting samples, acc/cnt advance on each transfer
// ST_HOLD  | block total presented on acc_out, waiting for out_ready
module adder_sum_accumulator #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int ACC_W = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    adder_sum_accumulator_if.slave bus
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             out_vld;

    logic [WIDTH:0]   sample;
    logic [SUM_W-1:0] sum_ext;
    logic             carry;
    logic [ACC_W-1:0] acc_nxt;

    assign sample  = {bus.carry_in, bus.sum_in};
    assign sum_ext = {1'b0, acc} + SUM_W'(sample);
    assign carry   = sum_ext[ACC_W];

`ifdef ADDER_SUM_ACC_SAT_EN
    // Once clamped, stay at full scale for the remainder of the block.
    assign acc_nxt = (carry || ovf) ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_vld <= 1'b0;
        end else if (clear) begin
            state   <= ST_ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= acc_nxt;
                        ovf <= ovf | carry;
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            out_vld <= 1'b1;
                            state   <= ST_HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        out_vld <= 1'b0;
                        state   <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // Every output comes straight from a register or the state bit.
    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = out_vld;
    assign bus.acc_out   = acc;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench: ACC_W=11 instance for block behaviour, ACC_W=10 instance for overflow handling.
module tb_adder_sum_accumulator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] sum_in = 8'h00;
    logic       carry_in = 1'b0;
    logic       out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int pulses;

    adder_sum_accumulator_if #(.WIDTH(8), .ACC_W(11)) bus_a ();
    adder_sum_accumulator_if #(.WIDTH(8), .ACC_W(10)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.sum_in    = sum_in;
    assign bus_a.carry_in  = carry_in;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.sum_in    = sum_in;
    assign bus_b.carry_in  = carry_in;
    assign bus_b.out_ready = out_ready;

    adder_sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_W(11)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus_a)
    );

    adder_sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_W(10)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] s, input logic c);
        in_valid = 1'b1;
        sum_in   = s;
        carry_in = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        chk("accept_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("accept_acc_zero", 32'(bus_a.acc_out), 32'd0);
        out_ready = 1'b0;
    endtask

    int gaps[8] = '{0, 3, 1, 2, 2, 0, 3, 1};

    initial begin
        // Power-on reset
        tick();
        tick();
        chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_acc_out", 32'(bus_a.acc_out), 32'd0);
        chk("rst_overflow", 32'(bus_a.overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-block discards the partial sum
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        chk("partial_acc", 32'(bus_a.acc_out), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_acc_out", 32'(bus_a.acc_out), 32'd0);
        chk("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus_a.in_ready), 32'd1);
        chk("midrst_overflow", 32'(bus_a.overflow), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h01, 1'b0);
            if (i == 2) chk("postrst_no_early_valid", 32'(bus_a.out_valid), 32'd0);
        end
        chk("postrst_out_valid", 32'(bus_a.out_valid), 32'd1);
        chk("postrst_acc_out", 32'(bus_a.acc_out), 32'd4);
        accept();

        // Basic block
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'hFF, 1'b1);
        chk("basic_no_early_valid", 32'(bus_a.out_valid), 32'd0);
        send(8'h01, 1'b0);
        chk("basic_out_valid", 32'(bus_a.out_valid), 32'd1);
        chk("basic_acc_out", 32'(bus_a.acc_out), 32'd560);
        chk("basic_overflow", 32'(bus_a.overflow), 32'd0);
        chk("basic_in_ready", 32'(bus_a.in_ready), 32'd0);

        // Back-pressure: samples offered during HOLD must be ignored
        in_valid = 1'b1;
        sum_in   = 8'h55;
        carry_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_acc_stable", 32'(bus_a.acc_out), 32'd560);
            chk("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
        end
        in_valid = 1'b0;
        accept();
        chk("bp_in_ready_after", 32'(bus_a.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
        chk("bp_next_block", 32'(bus_a.acc_out), 32'd4);
        accept();

        // Overflow: 4 x 511 = 2044 fits 11 bits, overflows 10 bits
        send(8'hFF, 1'b1);
        send(8'hFF, 1'b1);
        chk("ovf_b_two_samples", 32'(bus_b.overflow), 32'd0);
        send(8'hFF, 1'b1);
        chk("ovf_b_third_flag", 32'(bus_b.overflow), 32'd1);
`ifdef ADDER_SUM_ACC_SAT_EN
        chk("ovf_b_third_acc", 32'(bus_b.acc_out), 32'd1023);
`else
        chk("ovf_b_third_acc", 32'(bus_b.acc_out), 32'd509);
`endif
        send(8'hFF, 1'b1);
        chk("ovf_a_acc", 32'(bus_a.acc_out), 32'd2044);
        chk("ovf_a_flag", 32'(bus_a.overflow), 32'd0);
        chk("ovf_b_out_valid", 32'(bus_b.out_valid), 32'd1);
        chk("ovf_b_flag", 32'(bus_b.overflow), 32'd1);
`ifdef ADDER_SUM_ACC_SAT_EN
        chk("ovf_b_acc", 32'(bus_b.acc_out), 32'd1023);
`else
        chk("ovf_b_acc", 32'(bus_b.acc_out), 32'd1020);
`endif
        tick();
        chk("ovf_b_flag_held", 32'(bus_b.overflow), 32'd1);
        accept();
        chk("ovf_b_flag_cleared", 32'(bus_b.overflow), 32'd0);

        // Clear mid-block drops the partial sum and the clear-cycle sample
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        in_valid = 1'b1;
        sum_in   = 8'h80;
        carry_in = 1'b0;
        clear    = 1'b1;
        chk("clr_in_ready_during", 32'(bus_a.in_ready), 32'd1);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_acc_zero", 32'(bus_a.acc_out), 32'd0);
        chk("clr_in_ready", 32'(bus_a.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(8'h02, 1'b0);
            if (i == 2) chk("clr_no_early_valid", 32'(bus_a.out_valid), 32'd0);
        end
        chk("clr_out_valid", 32'(bus_a.out_valid), 32'd1);
        chk("clr_acc_out", 32'(bus_a.acc_out), 32'd8);

        // Clear during HOLD drops the pending total
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hold_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("clr_hold_acc", 32'(bus_a.acc_out), 32'd0);
        chk("clr_hold_in_ready", 32'(bus_a.in_ready), 32'd1);

        // Gapped input with out_ready held high
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                for (int g = 0; g < gaps[b*4+i]; g++) begin
                    tick();
                    if (bus_a.out_valid) pulses++;
                end
                send(8'h03, 1'b0);
                if (bus_a.out_valid) pulses++;
            end
            chk("gap_acc_out", 32'(bus_a.acc_out), 32'd12);
            for (int g = 0; g < 4; g++) begin
                tick();
                if (bus_a.out_valid) pulses++;
            end
            chk("gap_one_pulse", 32'(pulses), 32'd1);
        end
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Downstream consumer of the adder result stream (`sum_out`/`carry_out`). It accepts one `{carry, sum}` result per valid/ready transfer and accumulates COUNT consecutive results into a wider accumulator. It then presents the block total on a valid/ready output port and holds it until the output is accepted. It gives the adder environment a sequential checkpoint stage that can be exercised under back-pressure.

## Interface
- WIDTH, 8, width of the adder `sum` operand.
- COUNT, 4, accepted samples per output block; must be ≥ 2.
- ACC_W, 11, accumulator/result width; must be ≥ WIDTH+1.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous block abort, highest priority.
- in_valid  input  1  sample present on `sum_in`/`carry_in`.
- in_ready  output  1  block can accept a sample this cycle.
- sum_in  input  WIDTH  adder sum result.
- carry_in  input  1  adder carry result.
- out_valid  output  1  `acc_out` holds a completed block total.
- out_ready  input  1  consumer accepts `acc_out`.
- acc_out  output  ACC_W  block total.
- overflow  output  1  block total exceeded ACC_W bits; qualified by `out_valid`.

## Operation
- Sample value is `{carry_in, sum_in}`, i.e. WIDTH+1 bits, zero-extended to ACC_W before addition.
- State ACCUM:
  - `in_ready` = 1.
  - On each transfer (`in_valid` && `in_ready`): `acc <= acc + value` and `cnt <= cnt + 1`.
  - When the transfer is the COUNT-th sample (`cnt == COUNT-1`), the next cycle has `acc_out` = final sum, `out_valid` = 1, and the state moves to HOLD.
- State HOLD:
  - `in_ready` = 0; `in_valid` is ignored and no sample is consumed.
  - `acc_out` and `overflow` are held stable.
  - On `out_valid` && `out_ready`, the next cycle has `out_valid` = 0, `acc`/`cnt`/`overflow` = 0, and the state returns to ACCUM.
- Overflow: if any addition in a block carries out of bit ACC_W-1, `overflow` is set. It stays set until the block is accepted or cleared. The accumulator wraps modulo 2^ACC_W, unless saturation is compiled in (see Configuration).
- `clear`:
  - In any state it forces ACCUM, `acc` = 0, `cnt` = 0, `out_valid` = 0, `overflow` = 0.
  - A sample presented in the same cycle as `clear` is dropped, even though `in_ready` reads 1.
- `in_valid` gaps are allowed. `cnt` advances only on transfers.

## Timing
- Reset values: `in_ready` = 1 (state ACCUM), `out_valid` = 0, `acc_out` = 0, `overflow` = 0. Internal `acc` = 0 and `cnt` = 0.
- Reset may be asserted mid-block or during HOLD. It aborts the block immediately; the partial sum is discarded.
- Latency: `out_valid` rises 1 cycle after the clock edge that accepts the COUNT-th sample.
- Minimum block period: COUNT + 1 cycles (COUNT transfers plus 1 HOLD cycle with `out_ready` = 1).
- `in_ready`, `out_valid`, `acc_out` and `overflow` are all driven from registers/state only. There is no combinational path from any input to any output.
- `out_valid`, once asserted, stays high until accepted or until `clear`/reset.

## Configuration
- Macro: `ADDER_SUM_ACC_SAT_EN`.
- Defined: on overflow the accumulator clamps to 2^ACC_W−1 and remains clamped for the rest of the block. `overflow` is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W and `overflow` is set.

## Test plan
- Reset: assert `rst_n` = 0 after 2 of 4 samples, then release. Required: `out_valid` = 0, `acc_out` = 0, `overflow` = 0, `in_ready` = 1. The next 4 samples of (0x01, 0) give `acc_out` = 4.
- Basic block (WIDTH=8, COUNT=4, ACC_W=11): samples (0x10,0), (0x20,0), (0xFF,1), (0x01,0). Required: `acc_out` = 0x230 (560), `overflow` = 0, `out_valid` high the cycle after the 4th transfer.
- Back-pressure: hold `out_ready` = 0 for 5 cycles after `out_valid`, with `in_valid` = 1 throughout. Required: `acc_out` stable, `in_ready` = 0, no sample consumed. After acceptance, the next block starts from 0.
- Overflow with ACC_W=10: four samples of (0xFF,1).
  - Without the macro: `acc_out` = 1020, `overflow` = 1.
  - With `ADDER_SUM_ACC_SAT_EN`: `acc_out` = 1023, `overflow` = 1.
- Clear: after 2 samples of (0x40,0), pulse `clear` with `in_valid` = 1 on (0x80,0), then send 4 samples of (0x02,0). Required: the clear-cycle sample is dropped and the block result is `acc_out` = 8.
- Gapped input: 4 samples of (0x03,0) separated by 0–3 idle cycles, with `out_ready` = 1. Required: `acc_out` = 12, with exactly one `out_valid` cycle per block.
